// File: rtl/twiddle_conj_rot_if.sv
// Sample/result handshake bundle for the conjugate twiddle rotator.
// Master drives samples and result-ready; slave is the rotator.
interface twiddle_conj_rot_if #(
    parameter int W = 16
);
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] real_op;
    logic [W-1:0] image_op;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    modport master (
        output ra, rb, in_valid, out_ready,
        input  in_ready, real_op, image_op, out_valid, busy
    );

    modport slave (
        input  ra, rb, in_valid, out_ready,
        output in_ready, real_op, image_op, out_valid, busy
    );
endinterface

// File: rtl/twiddle_conj_rot.sv
// Serial shift-add rotator: (a + jb) * (1 - j)/sqrt2, Q1.(W-1).
// One constant-multiply bit per cycle, MSB-first, both components in lockstep.
module twiddle_conj_rot #(
    parameter int N = 4,
    parameter int W = 2**N,
    parameter int K = 23170
) (
    input logic clk,
    input logic rst,
    twiddle_conj_rot_if.slave bus
);
    localparam int AW = 2*W + 1;
    localparam int CW = $clog2(W) + 1;
    localparam logic [W-2:0] KV = K[W-2:0];
    localparam logic signed [AW-1:0] HI = AW'((64'sd1 <<< (W-1)) - 64'sd1);
    localparam logic signed [AW-1:0] LO = -HI - AW'(1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t state_q, state_d;
    logic signed [W:0]    sre_q, sre_d, sim_q, sim_d;
    logic signed [AW-1:0] are_q, are_d, aim_q, aim_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [W-1:0]         re_q, re_d, im_q, im_d;
    logic                 kbit;

    // Floor-shift the exact product back to Q1.(W-1) and clamp to range.
    function automatic logic [W-1:0] sat(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] sh;
        sh = acc >>> (W-1);
        if (sh > HI) sh = HI;
        else if (sh < LO) sh = LO;
        return sh[W-1:0];
    endfunction

    assign kbit = KV[cnt_q[CW-2:0]];

    // State and datapath registers; reset drops any sample in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sre_q   <= '0;
            sim_q   <= '0;
            are_q   <= '0;
            aim_q   <= '0;
            cnt_q   <= '0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            state_q <= state_d;
            sre_q   <= sre_d;
            sim_q   <= sim_d;
            are_q   <= are_d;
            aim_q   <= aim_d;
            cnt_q   <= cnt_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    // Next state: capture sums, run W-1 shift-add steps, then round and hold.
    always_comb begin
        state_d = state_q;
        sre_d   = sre_q;
        sim_d   = sim_q;
        are_d   = are_q;
        aim_d   = aim_q;
        cnt_d   = cnt_q;
        re_d    = re_q;
        im_d    = im_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sre_d   = $signed({bus.rb[W-1], bus.rb})
                            + $signed({bus.ra[W-1], bus.ra});
                    sim_d   = $signed({bus.rb[W-1], bus.rb})
                            - $signed({bus.ra[W-1], bus.ra});
                    are_d   = '0;
                    aim_d   = '0;
                    cnt_d   = CW'(W-2);
                    state_d = MUL;
                end
            end
            MUL: begin
                // Counter underflow into its top bit marks the rounding edge.
                if (!cnt_q[CW-1]) begin
                    are_d = (are_q <<< 1)
                          + (kbit ? {{(AW-W-1){sre_q[W]}}, sre_q} : '0);
                    aim_d = (aim_q <<< 1)
                          + (kbit ? {{(AW-W-1){sim_q[W]}}, sim_q} : '0);
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    re_d    = sat(are_q);
                    im_d    = sat(aim_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.real_op   = re_q;
    assign bus.image_op  = im_q;
endmodule

// File: tb/tb_twiddle_conj_rot.sv
// Self-checking bench for twiddle_conj_rot (W=16, K=23170).
// Random and directed samples checked against an integer reference.
module tb_twiddle_conj_rot;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    twiddle_conj_rot_if #(.W(16)) bus();

    twiddle_conj_rot dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rot(input longint s);
        longint p;
        longint q;
        p = s * 64'sd23170;
        q = p / 64'sd32768;
        if (p < 0 && (p % 64'sd32768) != 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    task automatic model(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] re, output logic [15:0] im);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        re = rot(sa + sb);
        im = rot(sb - sa);
    endtask

    // Count edges from the accept edge until out_valid (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.out_valid === 1'b1) break;
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        output int lat);
        bus.ra = a;
        bus.rb = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_result(lat);
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.ra = '0;
        bus.rb = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        tests++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            fails++;
            $display("FAIL reset_flags got=%b want=100",
                     {bus.in_ready, bus.out_valid, bus.busy});
        end
        tests++;
        if ({bus.real_op, bus.image_op} !== 32'h0) begin
            fails++;
            $display("FAIL reset_data got=%h want=00000000",
                     {bus.real_op, bus.image_op});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [15:0] av [4];
        logic [15:0] bv [4];
        logic [15:0] er [4];
        logic [15:0] ei [4];
        int lat;
        av = '{16'h4000, 16'h7FFF, 16'h8000, 16'h0001};
        bv = '{16'h0000, 16'h7FFF, 16'h8000, 16'h0000};
        er = '{16'h2D41, 16'h7FFF, 16'h8000, 16'h0000};
        ei = '{16'hD2BF, 16'h0000, 16'h0000, 16'hFFFF};
        for (int i = 0; i < 4; i++) begin
            send(av[i], bv[i], lat);
            tests++;
            if (lat !== 16) begin
                fails++;
                $display("FAIL dir%0d_latency got=%0d want=16", i, lat);
            end
            tests++;
            if (bus.real_op !== er[i]) begin
                fails++;
                $display("FAIL dir%0d_real got=%h want=%h",
                         i, bus.real_op, er[i]);
            end
            tests++;
            if (bus.image_op !== ei[i]) begin
                fails++;
                $display("FAIL dir%0d_imag got=%h want=%h",
                         i, bus.image_op, ei[i]);
            end
            release_result();
            tests++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                fails++;
                $display("FAIL dir%0d_release got=%b%b want=01",
                         i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] er;
        logic [15:0] ei;
        int lat;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            model(a, b, er, ei);
            send(a, b, lat);
            tests++;
            if (lat !== 16 || bus.real_op !== er || bus.image_op !== ei) begin
                fails++;
                $display("FAIL rand%0d a=%h b=%h got=%0d/%h/%h want=16/%h/%h",
                         i, a, b, lat, bus.real_op, bus.image_op, er, ei);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            release_result();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] r0;
        logic [15:0] i0;
        logic [15:0] er;
        logic [15:0] ei;
        int lat;
        int bad;
        send(16'h1234, 16'hF00D, lat);
        model(16'h1234, 16'hF00D, er, ei);
        tests++;
        if (bus.real_op !== er || bus.image_op !== ei) begin
            fails++;
            $display("FAIL bp_first got=%h/%h want=%h/%h",
                     bus.real_op, bus.image_op, er, ei);
        end
        r0 = bus.real_op;
        i0 = bus.image_op;
        bus.ra = 16'h6A5C;
        bus.rb = 16'h9E21;
        bus.in_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.real_op !== r0 || bus.image_op !== i0 ||
                bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL bp_hold got=%0d bad cycles want=0", bad);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release got=%b%b want=01",
                     bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL bp_accept busy got=%b want=1", bus.busy);
        end
        wait_result(lat);
        model(16'h6A5C, 16'h9E21, er, ei);
        tests++;
        if (lat !== 16 || bus.real_op !== er || bus.image_op !== ei) begin
            fails++;
            $display("FAIL bp_second got=%0d/%h/%h want=16/%h/%h",
                     lat, bus.real_op, bus.image_op, er, ei);
        end
        release_result();
    endtask

    task automatic test_reset_mid();
        logic [15:0] er;
        logic [15:0] ei;
        int lat;
        bus.ra = 16'h5555;
        bus.rb = 16'h2222;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin
            fails++;
            $display("FAIL midrst_flags got=%b want=001",
                     {bus.out_valid, bus.busy, bus.in_ready});
        end
        tests++;
        if ({bus.real_op, bus.image_op} !== 32'h0) begin
            fails++;
            $display("FAIL midrst_data got=%h want=00000000",
                     {bus.real_op, bus.image_op});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(16'h1000, 16'h2000, lat);
        model(16'h1000, 16'h2000, er, ei);
        tests++;
        if (lat !== 16 || bus.real_op !== er || bus.image_op !== ei) begin
            fails++;
            $display("FAIL midrst_after got=%0d/%h/%h want=16/%h/%h",
                     lat, bus.real_op, bus.image_op, er, ei);
        end
        release_result();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
